aes_sbox_array: RTL and testbench

//  Pipelined multi-lane AES byte-substitution engine. Applies SubBytes (fwd) or InvSubBytes (inv) to LANES bytes per beat.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_sbox_lut.sv | 12 +
 rtl/aes_sbox_array.sv | 115 +++++++++++
 tb/tb_aes_sbox_array.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-substitution tables and a single-byte lookup helper.
// Used by the S-box array, key expansion and round datapath.
package aes_pkg;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b, input logic inv);
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// Combinational single-byte forward/inverse S-box lookup.
module aes_sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic       inv,
    output logic [7:0] byte_out
);

    assign byte_out = sbox_byte(byte_in, inv);

endmodule

// File: rtl/aes_sbox_array.sv
// Pipelined multi-lane SubBytes/InvSubBytes engine with valid/ready flow control.
// The lookup sits after stage 0 (or before the only stage when PIPE=1).
module aes_sbox_array
    import aes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIPE  = 2,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int DW = 8 * LANES;

    logic [PIPE-1:0]  v_q;
    logic [PIPE-1:0]  adv;
    logic [PIPE-1:0]  in_v;
    logic [DW-1:0]    data_q [PIPE];
    logic [DW-1:0]    data_d [PIPE];
    logic [TAG_W-1:0] tag_q  [PIPE];
    logic [TAG_W-1:0] tag_d  [PIPE];
    logic [DW-1:0]    lut_in;
    logic [DW-1:0]    lut_out;
    logic             lut_inv;
    logic             go;

    // A stage moves when it is empty or its successor moves; empty stages
    // therefore fill even while the output is stalled.
    always_comb begin
        adv = '0;
        go  = !v_q[PIPE-1] || out_ready;
        adv[PIPE-1] = go;
        for (int k = PIPE - 2; k >= 0; k--) begin
            go     = !v_q[k] || go;
            adv[k] = go;
        end
    end

    always_comb begin
        in_v      = '0;
        in_v[0]   = in_valid;
        data_d[0] = (PIPE == 1) ? lut_out : in_data;
        tag_d[0]  = in_tag;
        for (int k = 1; k < PIPE; k++) begin
            in_v[k]   = v_q[k-1];
            data_d[k] = (k == 1) ? lut_out : data_q[k-1];
            tag_d[k]  = tag_q[k-1];
        end
    end

    generate
        if (PIPE == 1) begin : g_lut_front
            assign lut_in  = in_data;
            assign lut_inv = in_inv;
        end else begin : g_lut_stage0
            logic inv_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    inv_q <= 1'b0;
                end else if (adv[0] && in_valid) begin
                    inv_q <= in_inv;
                end
            end

            assign lut_in  = data_q[0];
            assign lut_inv = inv_q;
        end
    endgenerate

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lut u_lut (
            .byte_in  (lut_in[8*i +: 8]),
            .inv      (lut_inv),
            .byte_out (lut_out[8*i +: 8])
        );
    end

    // Payload only loads with a valid beat; the valid bits alone decide visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (adv[k]) begin
                    v_q[k] <= in_v[k];
                    if (in_v[k]) begin
                        data_q[k] <= data_d[k];
                        tag_q[k]  <= tag_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[PIPE-1];
    assign out_data  = data_q[PIPE-1];
    assign out_tag   = tag_q[PIPE-1];

endmodule

// File: tb/tb_aes_sbox_array.sv
// Self-checking bench for aes_sbox_array: constant vectors plus a scoreboard
// driven by an S-box model derived from GF(2^8) inversion and the affine map.
module tb_aes_sbox_array;

    localparam int LANES = 4;
    localparam int PIPE  = 2;
    localparam int TAG_W = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_inv;
    logic [31:0] in_data;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    aes_sbox_array #(.LANES(LANES), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        inv;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    exp_t        exp_q[$];
    logic [7:0]  fwd_tab [256];
    logic [7:0]  inv_tab [256];
    int          check_count = 0;
    int          pass_count  = 0;
    int          pop_count   = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = x << 1;
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} >> (8 - n);
        return t[7:0];
    endfunction

    function automatic logic [31:0] ref_sub(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        return r;
    endfunction

    task automatic buildModel();
        logic [7:0] a;
        logic [7:0] ainv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            a    = 8'(x);
            ainv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (a != 8'h00 && gmul(a, 8'(y)) == 8'h01) ainv = 8'(y);
            s = ainv ^ rotl8(ainv, 1) ^ rotl8(ainv, 2) ^ rotl8(ainv, 3) ^ rotl8(ainv, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = a;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic inv, input logic [31:0] d,
                                 input logic [3:0] t, input logic ordy);
        in_valid  = v;
        in_inv    = inv;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drainPipe();
        int n;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            nextCycle();
            n++;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: expectations are pushed on accept and popped on emit.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL unexpected_beat: got data %0h tag %0h, expected no beat", out_data, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("scoreboard_data", 64'(out_data), 64'(e.data));
                    checkOutput("scoreboard_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back('{data: ref_sub(in_data, in_inv), tag: in_tag});
        end
    end

    initial begin
        vec_t        vecs [6];
        int          n;
        int          accepted;
        int          sent;
        int          cyc;
        int          pops0;
        int          cnt;
        logic        fire;
        logic [11:0] ov;
        logic [31:0] held;
        logic [31:0] beat;
        logic [7:0]  j;

        vecs[0] = '{data: 32'h00010253, inv: 1'b0, tag: 4'h5, exp: 32'h637C77ED};
        vecs[1] = '{data: 32'h637C77ED, inv: 1'b1, tag: 4'hA, exp: 32'h00010253};
        vecs[2] = '{data: 32'h00000016, inv: 1'b1, tag: 4'h3, exp: 32'h525252FF};
        vecs[3] = '{data: 32'h000000FF, inv: 1'b0, tag: 4'hC, exp: 32'h63636316};
        vecs[4] = '{data: 32'hFFFFFFFF, inv: 1'b0, tag: 4'h7, exp: 32'h16161616};
        vecs[5] = '{data: 32'h16161616, inv: 1'b1, tag: 4'h9, exp: 32'hFFFFFFFF};

        buildModel();

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        nextCycle();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].inv, vecs[i].data, vecs[i].tag, 1'b1);
            nextCycle();
            applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
            n = 0;
            while (!out_valid && n < 8) begin
                nextCycle();
                n++;
            end
            checkOutput("vec_latency", 64'(n), 64'(PIPE - 1));
            checkOutput("vec_data", 64'(out_data), 64'(vecs[i].exp));
            checkOutput("vec_tag", 64'(out_tag), 64'(vecs[i].tag));
            nextCycle();
        end

        pops0 = pop_count;
        ov = '0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(c < 8, 1'(c % 2), $urandom, 4'(c), 1'b1);
            #1;
            if (c < 8) checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
            nextCycle();
            ov[c] = out_valid;
        end
        checkOutput("stream_valid_pattern", 64'(ov), 64'h1FE);
        checkOutput("stream_beats", 64'(pop_count - pops0), 64'd8);
        drainPipe();

        pops0    = pop_count;
        accepted = 0;
        held     = '0;
        beat     = $urandom;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 1'(accepted % 2), beat, 4'(accepted), 1'b0);
            #1;
            fire = in_ready;
            nextCycle();
            if (fire) begin
                accepted++;
                beat = $urandom;
            end
            if (c == 1) held = out_data;
        end
        checkOutput("bp_accepted", 64'(accepted), 64'(PIPE));
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_out_stable", 64'(out_data), 64'(held));
        drainPipe();
        checkOutput("bp_beats_out", 64'(pop_count - pops0), 64'(PIPE));

        pops0 = pop_count;
        sent  = 0;
        cyc   = 0;
        while (sent < 512 && cyc < 6000) begin
            j = 8'(sent % 256);
            applyStimulus($urandom_range(0, 3) != 0, sent >= 256,
                          {j + 8'd192, j + 8'd128, j + 8'd64, j}, 4'(sent),
                          1'($urandom_range(0, 1)));
            #1;
            fire = in_valid && in_ready;
            nextCycle();
            if (fire) sent++;
            cyc++;
        end
        checkOutput("sweep_sent", 64'(sent), 64'd512);
        drainPipe();
        checkOutput("sweep_beats_out", 64'(pop_count - pops0), 64'd512);

        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, $urandom, 4'(c), 1'b0);
            nextCycle();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_out_data", 64'(out_data), 64'd0);
        exp_q.delete();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        #7;
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            if (out_valid) cnt++;
        end
        checkOutput("post_reset_beats", 64'(cnt), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
